// File: rtl/ray_tracer_seq.sv
// Sequential ray tracer: walks every scene object once, keeps the nearest hit,
// then shades the pixel and holds the result until downstream accepts it.
module ray_tracer_seq #(
  parameter int unsigned N_OBJ           = 8,
  parameter int unsigned T_W             = 10,
  parameter int unsigned COLLISION_BOUND = 2,
  parameter int unsigned TRACING_BOUND   = 200,
  parameter int unsigned SHADE_MODE      = 0,
  localparam int unsigned A_W            = $clog2(N_OBJ)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [27:0]    init,
  input  logic [27:0]    dir,
  output logic           busy,
  output logic [27:0]    ray_init,
  output logic [27:0]    ray_dir,
  output logic           obj_req,
  output logic [A_W-1:0] obj_addr,
  input  logic [T_W-1:0] t_in,
  input  logic           t_valid,
  output logic [11:0]    dout,
  output logic [A_W-1:0] hit_id,
  output logic [T_W-1:0] t_min,
  output logic           collision_sig,
  output logic           out_valid,
  input  logic           out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [A_W-1:0] cnt_q, cnt_d;
  logic [27:0]    ray_init_q, ray_init_d;
  logic [27:0]    ray_dir_q, ray_dir_d;
  logic           busy_q, busy_d;
  logic           obj_req_q, obj_req_d;
  logic [A_W-1:0] obj_addr_q, obj_addr_d;
  logic [T_W-1:0] t_min_q, t_min_d;
  logic [A_W-1:0] hit_id_q, hit_id_d;
  logic [11:0]    dout_q, dout_d;
  logic           coll_q, coll_d;
  logic           out_valid_q, out_valid_d;

  // Miss (beyond tracing range) is black; otherwise white or gray by depth.
  function automatic logic [11:0] shade_f(input logic [T_W-1:0] t);
    logic [3:0] g;
    g = 4'hF - t[T_W-1 -: 4];
    if (32'(t) > TRACING_BOUND) begin
      shade_f = 12'h000;
    end else if (SHADE_MODE == 32'd1) begin
      shade_f = {g, g, g};
    end else begin
      shade_f = 12'hFFF;
    end
  endfunction

  function automatic logic collide_f(input logic [T_W-1:0] t);
    collide_f = (32'(t) <= COLLISION_BOUND);
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ray_init_d  = ray_init_q;
    ray_dir_d   = ray_dir_q;
    obj_req_d   = 1'b0;
    obj_addr_d  = obj_addr_q;
    t_min_d     = t_min_q;
    hit_id_d    = hit_id_q;
    dout_d      = dout_q;
    coll_d      = coll_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ray_init_d = init;
          ray_dir_d  = dir;
          cnt_d      = '0;
          t_min_d    = '1;
          hit_id_d   = '0;
          obj_req_d  = 1'b1;
          obj_addr_d = '0;
          state_d    = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (t_valid) begin
          // Strict compare so ties keep the lower object index.
          if (t_in < t_min_q) begin
            t_min_d  = t_in;
            hit_id_d = cnt_q;
          end else begin
            t_min_d  = t_min_q;
          end
          if (cnt_q == A_W'(N_OBJ - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            coll_d      = collide_f(t_min_d);
            dout_d      = shade_f(t_min_d);
          end else begin
            cnt_d      = cnt_q + A_W'(1);
            obj_req_d  = 1'b1;
            obj_addr_d = cnt_q + A_W'(1);
            state_d    = FETCH;
          end
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ray_init_q  <= 28'd0;
      ray_dir_q   <= 28'd0;
      busy_q      <= 1'b0;
      obj_req_q   <= 1'b0;
      obj_addr_q  <= '0;
      t_min_q     <= '1;
      hit_id_q    <= '0;
      dout_q      <= 12'h000;
      coll_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ray_init_q  <= ray_init_d;
      ray_dir_q   <= ray_dir_d;
      busy_q      <= busy_d;
      obj_req_q   <= obj_req_d;
      obj_addr_q  <= obj_addr_d;
      t_min_q     <= t_min_d;
      hit_id_q    <= hit_id_d;
      dout_q      <= dout_d;
      coll_q      <= coll_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy          = busy_q;
  assign ray_init      = ray_init_q;
  assign ray_dir       = ray_dir_q;
  assign obj_req       = obj_req_q;
  assign obj_addr      = obj_addr_q;
  assign t_min         = t_min_q;
  assign hit_id        = hit_id_q;
  assign dout          = dout_q;
  assign collision_sig = coll_q;
  assign out_valid     = out_valid_q;

endmodule

// File: tb/tb_ray_tracer_seq.sv
// Scoreboard bench for ray_tracer_seq: binary and gray-shaded instances run in lockstep
// against a behavioural intersection unit with programmable latency.
module tb_ray_tracer_seq;
  localparam int N  = 8;
  localparam int TW = 10;

  typedef struct {
    logic [2:0]    hit;
    logic [TW-1:0] tmin;
    logic [11:0]   d0;
    logic [11:0]   d1;
    logic          coll;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, t_valid, out_ready;
  logic [27:0]   init, dir;
  logic [TW-1:0] t_in;

  logic busy0, busy1, obj_req0, obj_req1, coll0, coll1, out_valid0, out_valid1;
  logic [27:0] ray_init0, ray_init1, ray_dir0, ray_dir1;
  logic [2:0]  obj_addr0, obj_addr1, hit0, hit1;
  logic [TW-1:0] t_min0, t_min1;
  logic [11:0] dout0, dout1;

  ray_tracer_seq #(.N_OBJ(N), .T_W(TW), .SHADE_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .init(init), .dir(dir), .busy(busy0),
    .ray_init(ray_init0), .ray_dir(ray_dir0), .obj_req(obj_req0), .obj_addr(obj_addr0),
    .t_in(t_in), .t_valid(t_valid), .dout(dout0), .hit_id(hit0), .t_min(t_min0),
    .collision_sig(coll0), .out_valid(out_valid0), .out_ready(out_ready));

  ray_tracer_seq #(.N_OBJ(N), .T_W(TW), .SHADE_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .init(init), .dir(dir), .busy(busy1),
    .ray_init(ray_init1), .ray_dir(ray_dir1), .obj_req(obj_req1), .obj_addr(obj_addr1),
    .t_in(t_in), .t_valid(t_valid), .dout(dout1), .hit_id(hit1), .t_min(t_min1),
    .collision_sig(coll1), .out_valid(out_valid1), .out_ready(out_ready));

  int checks = 0;
  int failures = 0;
  int lat_fix = 1;
  int exp_addr = 0;
  int req_count = 0;
  int lock_bad = 0;
  logic [TW-1:0] tvals [N];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input int h, input int t, input logic [11:0] d0,
                              input logic [11:0] d1, input logic c);
    exp_t e;
    e.hit = 3'(h); e.tmin = TW'(t); e.d0 = d0; e.d1 = d1; e.coll = c;
    return e;
  endfunction

  // Intersection unit model: answers each request L cycles later, checks request order.
  initial begin
    int cd;
    int pa;
    cd = 0; pa = 0;
    t_valid = 1'b0; t_in = '0;
    forever begin
      @(negedge clk);
      t_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          t_in = tvals[pa];
          t_valid = 1'b1;
        end
      end
      if (obj_req0 === 1'b1) begin
        chk("obj_addr_order", 32'(obj_addr0), 32'(exp_addr));
        exp_addr = (exp_addr + 1) % N;
        req_count++;
        pa = int'(obj_addr0);
        cd = (lat_fix > 0) ? lat_fix : int'($urandom_range(4, 1));
      end
    end
  end

  // Both instances must share all non-shading behaviour cycle for cycle.
  initial begin
    forever begin
      @(negedge clk); #1;
      if ({busy0, obj_req0, obj_addr0, ray_init0, ray_dir0, out_valid0, hit0, t_min0, coll0} !==
          {busy1, obj_req1, obj_addr1, ray_init1, ray_dir1, out_valid1, hit1, t_min1, coll1})
        lock_bad++;
    end
  end

  // Scoreboard monitor: compare on every accepted result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (out_valid0 === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_valid actual=1 expected=0 t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("hit_id", 32'(hit0), 32'(e.hit));
          chk("t_min", 32'(t_min0), 32'(e.tmin));
          chk("dout_bin", 32'(dout0), 32'(e.d0));
          chk("dout_gray", 32'(dout1), 32'(e.d1));
          chk("collision", 32'(coll0), 32'(e.coll));
        end
      end
    end
  end

  task automatic run_trace(input int lat, input exp_t e, input bit hold, input bit pulse);
    int cyc;
    logic [27:0] org, dv;
    lat_fix = lat; req_count = 0;
    org = 28'($urandom); dv = 28'($urandom);
    exp_q.push_back(e);
    @(negedge clk);
    out_ready = hold ? 1'b0 : 1'b1;
    start = 1'b1; init = org; dir = dv;
    cyc = 0;
    while (out_valid0 !== 1'b1 && cyc < 200) begin
      @(negedge clk); cyc++;
      start = 1'b0;
      if (pulse && cyc == 5) begin start = 1'b1; init = ~org; dir = ~dv; end
      if (cyc == 7) begin
        chk("ray_init", 32'(ray_init0), 32'(org));
        chk("ray_dir", 32'(ray_dir0), 32'(dv));
      end
    end
    if (cyc >= 200) chk("out_valid_timeout", 32'(cyc), 32'd0);
    if (lat > 0) chk("latency", 32'(cyc), 32'(N * (1 + lat) + 1));
    if (hold) begin
      repeat (5) begin
        @(negedge clk);
        chk("hold_valid", 32'(out_valid0), 32'd1);
        chk("hold_dout", 32'(dout1), 32'(e.d1));
        chk("hold_tmin", 32'(t_min0), 32'(e.tmin));
        chk("hold_hit", 32'(hit0), 32'(e.hit));
        chk("hold_no_req", 32'(obj_req0), 32'd0);
      end
      out_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("accept_valid_drop", 32'(out_valid0), 32'd0);
      chk("accept_idle", 32'(busy0), 32'd0);
      @(negedge clk);
      chk("start_in_done_ignored", 32'(busy0), 32'd0);
    end else begin
      @(negedge clk);
      chk("accept_valid_drop", 32'(out_valid0), 32'd0);
    end
    chk("req_count", 32'(req_count), 32'(N));
  endtask

  initial begin
    int cyc;
    int bad;
    rst = 1'b1; start = 1'b0; init = '0; dir = '0; out_ready = 1'b1;
    tvals = '{default: 10'd1023};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_obj_req", 32'(obj_req0), 32'd0);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_t_min", 32'(t_min0), 32'h3FF);
    chk("rst_hit", 32'(hit0), 32'd0);
    chk("rst_dout", 32'(dout0), 32'd0);
    chk("rst_ray_init", 32'(ray_init0), 32'd0);
    chk("rst_collision", 32'(coll0), 32'd0);

    tvals = '{10'd300, 10'd150, 10'd40, 10'd40, 10'd1023, 10'd90, 10'd500, 10'd60};
    run_trace(1, mk(2, 40, 12'hFFF, 12'hFFF, 1'b0), 1'b0, 1'b0);
    tvals = '{10'd300, 10'd150, 10'd40, 10'd40, 10'd1023, 10'd1, 10'd500, 10'd60};
    run_trace(1, mk(5, 1, 12'hFFF, 12'hFFF, 1'b1), 1'b0, 1'b0);
    tvals = '{default: 10'd1023};
    run_trace(2, mk(0, 1023, 12'h000, 12'h000, 1'b0), 1'b0, 1'b0);
    tvals = '{10'd1023, 10'd201, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023};
    run_trace(1, mk(1, 201, 12'h000, 12'h000, 1'b0), 1'b0, 1'b0);
    tvals = '{10'd1023, 10'd500, 10'd128, 10'd128, 10'd300, 10'd1023, 10'd129, 10'd200};
    run_trace(1, mk(2, 128, 12'hFFF, 12'hDDD, 1'b0), 1'b1, 1'b0);
    tvals = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd200};
    run_trace(3, mk(7, 200, 12'hFFF, 12'hCCC, 1'b0), 1'b0, 1'b0);
    tvals = '{10'd50, 10'd3, 10'd2, 10'd2, 10'd9, 10'd9, 10'd9, 10'd9};
    run_trace(1, mk(2, 2, 12'hFFF, 12'hFFF, 1'b1), 1'b0, 1'b0);
    tvals = '{10'd9, 10'd4, 10'd3, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9};
    run_trace(1, mk(2, 3, 12'hFFF, 12'hFFF, 1'b0), 1'b0, 1'b0);
    tvals = '{10'd90, 10'd80, 10'd70, 10'd60, 10'd50, 10'd40, 10'd30, 10'd20};
    run_trace(0, mk(7, 20, 12'hFFF, 12'hFFF, 1'b0), 1'b0, 1'b1);

    // Reset while waiting on object 3; its late answer must be dropped.
    lat_fix = 2;
    tvals = '{10'd5, 10'd4, 10'd3, 10'd2, 10'd100, 10'd100, 10'd100, 10'd100};
    @(negedge clk);
    start = 1'b1; init = 28'h1234567; dir = 28'h7654321;
    cyc = 0;
    while (!(obj_req0 === 1'b1 && obj_addr0 == 3'd3) && cyc < 100) begin
      @(negedge clk); cyc++;
      start = 1'b0;
    end
    if (cyc >= 100) chk("obj3_timeout", 32'(cyc), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_obj_req", 32'(obj_req0), 32'd0);
    chk("midrst_t_min", 32'(t_min0), 32'h3FF);
    chk("midrst_ray_init", 32'(ray_init0), 32'd0);
    exp_addr = 0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid0 !== 1'b0 || obj_req0 !== 1'b0 || busy0 !== 1'b0) bad++;
    end
    chk("midrst_quiet", 32'(bad), 32'd0);
    run_trace(1, mk(3, 2, 12'hFFF, 12'hFFF, 1'b1), 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("lockstep", 32'(lock_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ray_tracer_seq.md
RAY_TRACER_SEQ -- requirements
Module: ray_tracer_seq

Interface
REQ-001 SHALL have parameter N_OBJ, default 8: number of scene objects traced per ray, 2..256.
REQ-002 SHALL have parameter T_W, default 10: intersection distance width, at least 4.
REQ-003 SHALL have parameter COLLISION_BOUND, default 2: t at or below this bound flags collision.
REQ-004 SHALL have parameter TRACING_BOUND, default 200: t above this bound shades as miss.
REQ-005 SHALL have parameter SHADE_MODE, default 0: 0 = binary black/white, 1 = depth-graded gray.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: begin tracing the ray on init/dir.
REQ-009 SHALL have port init, input, 28: ray origin.
REQ-010 SHALL have port dir, input, 28: ray direction.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port ray_init, output, 28: latched origin driven to the intersection unit.
REQ-013 SHALL have port ray_dir, output, 28: latched direction driven to the intersection unit.
REQ-014 SHALL have port obj_req, output, 1: one-cycle request to evaluate object obj_addr.
REQ-015 SHALL have port obj_addr, output, clog2(N_OBJ): index of the requested object.
REQ-016 SHALL have port t_in, input, T_W: intersection distance; all-ones means no hit.
REQ-017 SHALL have port t_valid, input, 1: t_in is valid for the outstanding request.
REQ-018 SHALL have port dout, output, 12: pixel colour {R4,G4,B4}.
REQ-019 SHALL have port hit_id, output, clog2(N_OBJ): index of the nearest object.
REQ-020 SHALL have port t_min, output, T_W: nearest distance.
REQ-021 SHALL have port collision_sig, output, 1: t_min <= COLLISION_BOUND.
REQ-022 SHALL have port out_valid, output, 1: result valid, held until accepted.
REQ-023 SHALL have port out_ready, input, 1: downstream accepts the result.

Function
REQ-024 SHALL implement FSM states IDLE, FETCH, WAIT, DONE.
REQ-025 SHALL, in IDLE with start=1, latch init/dir into ray_init/ray_dir, clear the object counter, preset t_min to all-ones and hit_id to 0, and go to FETCH.
REQ-026 SHALL ignore start in every state except IDLE.
REQ-027 SHALL, in FETCH, assert obj_req for exactly one cycle with obj_addr equal to the counter, then go to WAIT.
REQ-028 SHALL, in WAIT, hold obj_req=0 and the counter until t_valid=1; t_valid is guaranteed no earlier than the cycle after obj_req, and t_valid outside WAIT SHALL be ignored.
REQ-029 SHALL, on t_valid in WAIT, update t_min/hit_id only when t_in < t_min (strict), so ties keep the lower index.
REQ-030 SHALL, after that update, go to FETCH with counter+1 if counter < N_OBJ-1, else go to DONE.
REQ-031 SHALL compute, on entry to DONE and from the final t_min: collision_sig = (t_min <= COLLISION_BOUND); miss = (t_min > TRACING_BOUND).
REQ-032 SHALL, with SHADE_MODE=0, set dout = 12'h000 on miss, else 12'hFFF.
REQ-033 SHALL, with SHADE_MODE=1, set dout = 12'h000 on miss, else {g,g,g} with g = 4'hF minus t_min[T_W-1:T_W-4].
REQ-034 SHALL assert out_valid throughout DONE, with dout/hit_id/t_min/collision_sig stable until out_ready=1.
REQ-035 SHALL, in DONE with out_ready=1, drop out_valid on the next cycle and return to IDLE; start in that same cycle SHALL be ignored.
REQ-036 SHALL, if all objects return all-ones, finish with hit_id=0, t_min all-ones, dout=12'h000, collision_sig=0.
REQ-037 SHALL give a latency from start to out_valid of N_OBJ*(1+L)+1 cycles for a fixed intersection latency L; N_OBJ=8, L=1 gives 17 cycles.

Reset
REQ-038 SHALL, on rst=1 at a clock edge, enter IDLE and clear busy, obj_req, obj_addr, out_valid, collision_sig, dout, hit_id and ray_init/ray_dir, and set t_min to all-ones.
REQ-039 SHALL, on rst mid-trace, abandon the trace, drop any later t_valid, and produce no out_valid.

Verification
REQ-040 SHALL cover this case: N_OBJ=8, L=1, t values {300,150,40,40,1023,90,500,60}, SHADE_MODE=0 -> out_valid 17 cycles after start, hit_id=2, t_min=40, dout=FFF, collision_sig=0.
REQ-041 SHALL cover this case: object 5 returns t=1 -> hit_id=5, collision_sig=1.
REQ-042 SHALL cover this case: all objects return 1023 -> dout=000, hit_id=0, collision_sig=0; also minimum t=201 -> dout=000.
REQ-043 SHALL cover this case: SHADE_MODE=1, t_min=128 -> dout=DDD; out_ready held low for 5 cycles -> outputs stable, no new obj_req.
REQ-044 SHALL cover this case: random L from 1 to 4, start pulsed while busy -> ignored, exactly N_OBJ obj_req pulses with addresses 0..N_OBJ-1 in order.
REQ-045 SHALL cover this case: rst asserted in WAIT of object 3 -> IDLE next cycle, late t_valid ignored, a fresh start traces normally.
